// File: rtl/mips_pkg.sv
// Shared MIPS pipeline package: divider state encoding, datapath width and
// the HI/LO write-select codes used by the hazard and writeback logic.
package mips_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

    localparam logic [1:0] HILO_SEL_NONE = 2'b00;
    localparam logic [1:0] HILO_SEL_LO   = 2'b01;
    localparam logic [1:0] HILO_SEL_HI   = 2'b10;
    localparam logic [1:0] HILO_SEL_BOTH = 2'b11;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only if it did not borrow.
module div_step
    import mips_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Trial subtraction; the extra top bit acts as the borrow flag.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[WIDTH];
        rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU controller: iterative restoring divide on operand
// magnitudes with final sign correction, pipeline stall while busy, result
// hold until EX advances, and flush via cancel.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration and
// produces the same all-ones quotient / dividend remainder in one cycle.
module div_ctrl
    import mips_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] opaE,
    input  logic [WIDTH-1:0] opbE,
    input  logic             cancel,
    input  logic             ackE,
    output logic             stall_div,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic [WIDTH-1:0] opa_abs, opb_abs;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    // Operand magnitudes; 0x80000000 maps onto itself and is then treated as unsigned.
    always_comb begin
        opa_abs = cond_neg(opaE, signedE & opaE[WIDTH-1]);
        opb_abs = cond_neg(opbE, signedE & opbE[WIDTH-1]);
    end

    // Next-state, iteration datapath and result capture; cancel overrides everything.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        quo_neg_d   = quo_neg_q;
        rem_neg_d   = rem_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            IDLE: begin
                if (startE && !cancel) begin
                    rem_d     = '0;
                    dvd_d     = opa_abs;
                    dvs_d     = opb_abs;
                    quo_neg_d = signedE & (opaE[WIDTH-1] ^ opbE[WIDTH-1]);
                    rem_neg_d = signedE & opaE[WIDTH-1];
                    cnt_d     = '0;
                    state_d   = BUSY;
`ifdef DIV_ZERO_FAST_EN
                    if (opbE == '0) begin
                        quotient_d  = cond_neg('1, signedE & opaE[WIDTH-1]);
                        remainder_d = cond_neg(opa_abs, signedE & opaE[WIDTH-1]);
                        state_d     = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    quotient_d  = cond_neg({dvd_q[WIDTH-2:0], step_bit}, quo_neg_q);
                    remainder_d = cond_neg(step_rem, rem_neg_q);
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (ackE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cancel) begin
            state_d = IDLE;
        end
    end

    // Controller and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    // Status outputs; the stall request is dropped in the same cycle as a flush.
    always_comb begin
        stall_div    = ((state_q == IDLE && startE) || state_q == BUSY) && !cancel;
        busy         = (state_q != IDLE);
        result_valid = (state_q == DONE);
        quotient     = quotient_q;
        remainder    = remainder_q;
    end

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;
    import mips_pkg::*;

    localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         startE;
    logic         signedE;
    logic [W-1:0] opaE;
    logic [W-1:0] opbE;
    logic         cancel;
    logic         ackE;
    logic         stall_div;
    logic         busy;
    logic         result_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int checks;
    int passes;

    div_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .startE       (startE),
        .signedE      (signedE),
        .opaE         (opaE),
        .opbE         (opbE),
        .cancel       (cancel),
        .ackE         (ackE),
        .stall_div    (stall_div),
        .busy         (busy),
        .result_valid (result_valid),
        .quotient     (quotient),
        .remainder    (remainder)
    );

    // Free-running pipeline clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point: counts every check and reports any difference.
    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            passes++;
        end
    endtask

    // Architectural reference: MIPS DIV/DIVU semantics from plain arithmetic.
    function automatic void refModel(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb, lq, lr;
        if (!sgn) begin
            if (b == 0) begin
                q = '1;
                r = a;
            end else begin
                q = a / b;
                r = a % b;
            end
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            if (sb == 0) begin
                q = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
                r = a;
            end else begin
                lq = sa / sb;
                lr = sa % sb;
                q  = lq[31:0];
                r  = lr[31:0];
            end
        end
    endfunction

    // One complete divide: issue, measure stall/latency, check results, hold, acknowledge.
    task automatic applyStimulus(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int ackWait, input bit waitFirst, input bit keepStart);
        logic [W-1:0] expQ, expR;
        int expLat, lat, stallCnt;
        refModel(sgn, a, b, expQ, expR);
        expLat = (FAST && b == 0) ? 1 : W + 1;
        if (waitFirst) @(negedge clk);
        startE  = 1'b1;
        signedE = sgn;
        opaE    = a;
        opbE    = b;
        ackE    = 1'b0;
        lat      = -1;
        stallCnt = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (result_valid) begin
                lat = c;
                break;
            end
            if (stall_div) stallCnt++;
            @(negedge clk);
            opaE = $urandom;
            opbE = $urandom;
        end
        checkOutput("latency", W'(lat), W'(expLat));
        checkOutput("stallCycles", W'(stallCnt), W'(expLat));
        checkOutput("quotient", quotient, expQ);
        checkOutput("remainder", remainder, expR);
        checkOutput("doneStall", W'(stall_div), 32'd0);
        for (int k = 0; k < ackWait; k++) begin
            @(negedge clk);
            #1;
            checkOutput("holdValid", W'(result_valid), 32'd1);
            checkOutput("holdQuot", quotient, expQ);
            checkOutput("holdRem", remainder, expR);
            checkOutput("holdStall", W'(stall_div), 32'd0);
        end
        ackE = 1'b1;
        @(negedge clk);
        ackE   = 1'b0;
        startE = keepStart;
        #1;
        checkOutput("ackValid", W'(result_valid), 32'd0);
        checkOutput("ackBusy", W'(busy), 32'd0);
        checkOutput("ackStall", W'(stall_div), W'(keepStart));
    endtask

    // Randomly pick ordinary or corner-case operands.
    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return W'($urandom_range(1, 20));
            4: return ~W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        bit seen;
        bit prevKeep;
        bit keep;
        checks  = 0;
        passes  = 0;
        rst     = 1'b0;
        startE  = 1'b0;
        signedE = 1'b0;
        opaE    = '0;
        opbE    = '0;
        cancel  = 1'b0;
        ackE    = 1'b0;

        #2 rst = 1'b1;
        #1;
        checkOutput("rstStall", W'(stall_div), 32'd0);
        checkOutput("rstBusy", W'(busy), 32'd0);
        checkOutput("rstValid", W'(result_valid), 32'd0);
        checkOutput("rstQuot", quotient, 32'd0);
        checkOutput("rstRem", remainder, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed divides");
        applyStimulus(1'b0, 32'd7, 32'd2, 0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd1000, 32'd33, 5, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h1234, 32'd0, 0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hFFFF_FF00, 32'd0, 0, 1'b1, 1'b0);

        $display("[TB] cancel during iteration");
        @(negedge clk);
        startE = 1'b1; signedE = 1'b0; opaE = 32'd100; opbE = 32'd7;
        repeat (11) @(negedge clk);
        cancel = 1'b1;
        startE = 1'b0;
        #1;
        checkOutput("cancelStall", W'(stall_div), 32'd0);
        checkOutput("cancelBusyBefore", W'(busy), 32'd1);
        @(negedge clk);
        cancel = 1'b0;
        #1;
        checkOutput("cancelBusyAfter", W'(busy), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (result_valid) seen = 1'b1;
        end
        checkOutput("cancelNoResult", W'(seen), 32'd0);

        $display("[TB] cancel together with start");
        @(negedge clk);
        startE = 1'b1; cancel = 1'b1; opaE = 32'd50; opbE = 32'd5;
        #1;
        checkOutput("cancelStartStall", W'(stall_div), 32'd0);
        @(negedge clk);
        startE = 1'b0; cancel = 1'b0;
        #1;
        checkOutput("cancelStartBusy", W'(busy), 32'd0);

        $display("[TB] back-to-back divides");
        applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7, 0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'd12345, 32'hFFFF_FFFD, 2, 1'b0, 1'b0);

        $display("[TB] reset during iteration");
        @(negedge clk);
        startE = 1'b1; signedE = 1'b0; opaE = 32'd1000; opbE = 32'd3;
        repeat (15) @(negedge clk);
        rst    = 1'b1;
        startE = 1'b0;
        #1;
        checkOutput("midRstBusy", W'(busy), 32'd0);
        checkOutput("midRstStall", W'(stall_div), 32'd0);
        checkOutput("midRstValid", W'(result_valid), 32'd0);
        checkOutput("midRstQuot", quotient, 32'd0);
        checkOutput("midRstRem", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] randomized divides");
        prevKeep = 1'b0;
        for (int i = 0; i < 24; i++) begin
            keep = (i != 23) && ($urandom_range(0, 2) == 0);
            applyStimulus(1'($urandom_range(0, 1)), pickOperand(), pickOperand(),
                          $urandom_range(0, 3), !prevKeep, keep);
            prevKeep = keep;
        end
        startE = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle divide controller for the 5-stage MIPS pipeline.
- Accepts DIV/DIVU from the EX stage and runs an iterative radix-2 restoring division. Holds the pipeline through the hazard unit's stall request until the quotient (LO) and remainder (HI) are ready.
- Handles exception flush (cancel) and holding results while EX cannot advance.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- startE  in  1  divide instruction present in EX, level-held while stalled
- signedE  in  1  1 = DIV (signed), 0 = DIVU
- opaE  in  WIDTH  dividend (rs value after forwarding)
- opbE  in  WIDTH  divisor (rt value after forwarding)
- cancel  in  1  flush from exception/eret; aborts any operation
- ackE  in  1  EX stage advances this cycle (no other stall on stallE)
- stall_div  out  1  stall request, ORed into stallF/stallD/stallE by the hazard unit
- busy  out  1  state != IDLE
- result_valid  out  1  quotient/remainder valid
- quotient  out  WIDTH  to LO
- remainder  out  WIDTH  to HI

Behaviour:
- Reset (async, rst=1): state IDLE; counter 0; stall_div 0, busy 0, result_valid 0, quotient 0, remainder 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - startE=1 and cancel=0: latch |opa|, |opb|, sign_q = signedE & (opa[MSB]^opb[MSB]), sign_r = signedE & opa[MSB]; counter <= 0; go BUSY.
  - For unsigned operations, operands are used raw.
  - Abs of 0x80000000 is 0x80000000 treated as unsigned.
- BUSY:
  - One restoring step per cycle: shift partial remainder left, bring in the next dividend bit, trial subtract, set the quotient bit.
  - Counter increments each cycle. At counter == WIDTH-1, go DONE.
  - Exactly WIDTH cycles in BUSY.
- DONE:
  - result_valid=1.
  - quotient = sign_q ? -q : q; remainder = sign_r ? -r : r.
  - Registered outputs are held stable.
  - ackE=1: go IDLE next cycle, result_valid drops.
  - ackE=0: remain in DONE indefinitely.
- stall_div = (state==IDLE & startE & ~cancel) | (state==BUSY). It is 0 in DONE.
- Latency: start seen in cycle 0 → result_valid in cycle WIDTH+1 (33). stall_div is high for cycles 0..WIDTH.
- cancel: in any state, go IDLE next cycle; result_valid 0; stall_div forced 0 the same cycle. cancel beats startE in the same cycle.
- Divide by zero: the iteration runs normally. The unsigned raw result is q=all ones, r=opa; sign correction then applies as above. No trap.
- startE still high in the cycle after ackE (the next instruction is also a divide): IDLE accepts it as a new operation; no bubble beyond the IDLE cycle.
- Operands are sampled only on IDLE→BUSY. Later changes on opaE/opbE are ignored.
- rst asserted mid-BUSY: immediate return to reset values.

Optional Feature:
- Macro DIV_ZERO_FAST_EN.
- Defined: in IDLE, startE with opbE==0 goes directly to DONE next cycle. quotient/remainder are bit-identical to the full-iteration result. stall_div is high for 1 cycle only.
- Undefined: divide by zero takes the full WIDTH+1 cycles like any other operand.

Decomposition:
- Shared package (mips_pkg):
  - div_state_t enum {IDLE, BUSY, DONE}.
  - DIV_WIDTH=32.
  - HI/LO write-select constants used by the hazard/writeback logic.
- Sub-module div_step: purely combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
  - Instantiated once inside div_ctrl.

Test Plan:
- Unsigned: DIVU 7/2, startE held, ackE=1 once result_valid → stall_div high 33 cycles; quotient=3, remainder=1.
- Signed: DIV 0xFFFFFFF9(-7)/2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Cancel: start 100/7, assert cancel at BUSY cycle 10 → IDLE next cycle, stall_div=0, result_valid never 1. cancel together with startE in IDLE → no transition.
- ackE hold: result reached with ackE=0 for 5 cycles → DONE held, result_valid=1, outputs stable, stall_div=0. ackE=1 → IDLE next cycle.
- Divide by zero: DIVU 0x1234/0 → quotient=0xFFFFFFFF, remainder=0x1234. Latency 33 cycles without DIV_ZERO_FAST_EN, result_valid in cycle 1 with it.
- Back-to-back with reset: two consecutive DIVs with startE held across ackE → second result correct, one IDLE cycle between them. rst pulse mid-BUSY → all outputs 0 immediately.
